// File: rtl/ps2_host_tx.sv
// rtl/ps2_host_tx.sv - PS/2 host-to-device command byte transmitter
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int START_TIMEOUT  = 750000,
  parameter int XFER_TIMEOUT   = 100000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_done,
  output logic [1:0] tx_err,
  output logic       busy,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe
);

  localparam int MAX_A   = (INHIBIT_CYCLES > START_TIMEOUT) ? INHIBIT_CYCLES : START_TIMEOUT;
  localparam int MAX_CNT = (MAX_A > XFER_TIMEOUT) ? MAX_A : XFER_TIMEOUT;
  localparam int CW      = $clog2(MAX_CNT + 1);
  localparam logic [CW-1:0] INH_LAST   = CW'(INHIBIT_CYCLES - 1);
  localparam logic [CW-1:0] START_LAST = CW'(START_TIMEOUT - 1);
  localparam logic [CW-1:0] XFER_LAST  = CW'(XFER_TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE, INHIBIT, RTS, WAIT_CLK, SHIFT, ACK, WAIT_IDLE
  } state_t;

  state_t          state;
  logic [1:0]      clk_sync;
  logic [1:0]      data_sync;
  logic            clk_prev;
  logic            fall;
  logic [9:0]      shreg;
  logic [3:0]      bit_cnt;
  logic [CW-1:0]   cnt;
  logic [CW-1:0]   cnt_inc;

  // Pads idle high, so synchronizers reset high to avoid a false edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      clk_sync  <= 2'b11;
      data_sync <= 2'b11;
      clk_prev  <= 1'b1;
    end else begin
      clk_sync  <= {clk_sync[0], ps2_clk_i};
      data_sync <= {data_sync[0], ps2_data_i};
      clk_prev  <= clk_sync[1];
    end
  end

  assign fall    = clk_prev & ~clk_sync[1];
  assign cnt_inc = (cnt == {CW{1'b1}}) ? cnt : cnt + CW'(1);
  assign busy    = (state != IDLE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      tx_ready    <= 1'b1;
      tx_done     <= 1'b0;
      tx_err      <= 2'd0;
      ps2_clk_oe  <= 1'b0;
      ps2_data_oe <= 1'b0;
      shreg       <= '0;
      bit_cnt     <= '0;
      cnt         <= '0;
    end else begin
      tx_done <= 1'b0;
      case (state)
        IDLE: begin
          ps2_clk_oe  <= 1'b0;
          ps2_data_oe <= 1'b0;
          if (tx_valid && tx_ready) begin
            shreg      <= {1'b1, ~^tx_data, tx_data};
            bit_cnt    <= '0;
            tx_err     <= 2'd0;
            cnt        <= '0;
            tx_ready   <= 1'b0;
            ps2_clk_oe <= 1'b1;
            state      <= INHIBIT;
          end else begin
            tx_ready <= 1'b1;
          end
        end
        INHIBIT: begin
          if (cnt == INH_LAST) begin
            ps2_data_oe <= 1'b1;
            state       <= RTS;
          end else begin
            cnt <= cnt_inc;
          end
        end
        RTS: begin
          ps2_clk_oe <= 1'b0;
          cnt        <= '0;
          state      <= WAIT_CLK;
        end
        WAIT_CLK: begin
          if (fall) begin
            ps2_data_oe <= ~shreg[0];
            shreg       <= {1'b0, shreg[9:1]};
            bit_cnt     <= 4'd1;
            cnt         <= '0;
            state       <= SHIFT;
          end else if (cnt == START_LAST) begin
            ps2_data_oe <= 1'b0;
            tx_err      <= 2'd1;
            tx_done     <= 1'b1;
            state       <= IDLE;
          end else begin
            cnt <= cnt_inc;
          end
        end
        SHIFT, ACK, WAIT_IDLE: begin
          cnt <= cnt_inc;
          if (cnt == XFER_LAST) begin
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b0;
            tx_err      <= 2'd2;
            tx_done     <= 1'b1;
            state       <= IDLE;
          end else if (state == SHIFT) begin
            // Edge 10 shifts out the stop bit, whose inverse releases data.
            if (fall) begin
              ps2_data_oe <= ~shreg[0];
              shreg       <= {1'b0, shreg[9:1]};
              bit_cnt     <= bit_cnt + 4'd1;
              if (bit_cnt == 4'd9) state <= ACK;
            end
          end else if (state == ACK) begin
            if (fall) begin
              tx_err  <= data_sync[1] ? 2'd3 : 2'd0;
              bit_cnt <= bit_cnt + 4'd1;
              state   <= WAIT_IDLE;
            end
          end else if (clk_sync[1] && data_sync[1]) begin
            tx_done <= 1'b1;
            state   <= IDLE;
          end
        end
        default: begin
          ps2_clk_oe  <= 1'b0;
          ps2_data_oe <= 1'b0;
          state       <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb/tb_ps2_host_tx.sv - randomized bench for ps2_host_tx with a behavioural PS/2 device
module tb_ps2_host_tx;

  localparam int INH      = 50;
  localparam int START_TO = 400;
  localparam int XFER_TO  = 600;
  localparam int HALF     = 16;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       tx_done;
  logic [1:0] tx_err;
  logic       busy;
  logic       ps2_clk_i;
  logic       ps2_data_i;
  logic       ps2_clk_oe;
  logic       ps2_data_oe;
  logic       dev_clk;
  logic       dev_data;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;
  int lh          = 0;
  int done_cnt    = 0;
  int done_cyc, done_err, done_lh, done_ready, done_oe;

  ps2_host_tx #(
    .INHIBIT_CYCLES(INH),
    .START_TIMEOUT (START_TO),
    .XFER_TIMEOUT  (XFER_TO)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .tx_done    (tx_done),
    .tx_err     (tx_err),
    .busy       (busy),
    .ps2_clk_i  (ps2_clk_i),
    .ps2_data_i (ps2_data_i),
    .ps2_clk_oe (ps2_clk_oe),
    .ps2_data_oe(ps2_data_oe)
  );

  // Open-drain wired-AND of host and device
  assign ps2_clk_i  = ~ps2_clk_oe & dev_clk;
  assign ps2_data_i = ~ps2_data_oe & dev_data;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    lh  <= (ps2_clk_i && ps2_data_i) ? lh + 1 : 0;
  end

  always @(negedge clk) begin
    if (tx_done === 1'b1) begin
      done_cnt++;
      done_cyc   = cyc;
      done_err   = 32'(tx_err);
      done_lh    = lh;
      done_ready = 32'(tx_ready);
      done_oe    = 32'({ps2_clk_oe, ps2_data_oe});
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // mode: 0 ACKed, 1 device never clocks, 2 device stops after 5 edges, 3 no ACK
  task automatic xfer(input logic [7:0] d, input int mode, input bit poke_busy);
    int n, d_at, first_drop, base, t_fall, guard, nedges, lowlen;
    logic       p;
    logic [9:0] exp_bits;
    logic [9:0] got_bits;
    p        = ($countones(d) % 2 == 0);
    exp_bits = {1'b1, p, d};
    got_bits = '0;
    t_fall   = 0;
    base     = done_cnt;
    @(negedge clk);
    tx_data  = d;
    tx_valid = 1'b1;
    @(posedge clk); #1;
    tx_valid = 1'b0;
    check("accept_clk_oe", 32'(ps2_clk_oe), 1);
    check("accept_busy", 32'(busy), 1);
    n    = 1;
    d_at = 0;
    while (n < INH + 20) begin
      @(posedge clk); #1;
      if (ps2_clk_oe !== 1'b1) break;
      n++;
      if (ps2_data_oe === 1'b1 && d_at == 0) d_at = n;
    end
    check("inhibit_len", n, INH + 1);
    check("rts_data_first", d_at, INH + 1);
    check("start_bit_held", 32'(ps2_data_oe), 1);
    if (poke_busy) begin
      @(negedge clk);
      tx_data  = ~d;
      tx_valid = 1'b1;
      @(negedge clk);
      tx_valid = 1'b0;
    end
    if (mode == 1) begin
      n = poke_busy ? 2 : 0;
      while (ps2_data_oe === 1'b1 && n < START_TO + 20) begin
        @(posedge clk); #1;
        n++;
      end
      check("start_to_cycles", n, START_TO);
      check("start_to_clk_oe", 32'(ps2_clk_oe), 0);
    end else begin
      repeat (8) @(negedge clk);
      nedges = (mode == 2) ? 5 : 11;
      for (int k = 1; k <= nedges; k++) begin
        @(negedge clk);
        if (k == 11 && mode == 0) begin
          dev_data = 1'b0;
          @(negedge clk);
        end
        dev_clk = 1'b0;
        if (k == 1) t_fall = cyc;
        first_drop = 0;
        lowlen = (k == 11 && mode == 3) ? 3 * HALF : HALF;
        for (int i = 1; i <= lowlen; i++) begin
          @(negedge clk);
          if (k == 1 && first_drop == 0 && ps2_data_oe === 1'b0) first_drop = i;
        end
        if (k <= 10) got_bits = {ps2_data_i, got_bits[9:1]};
        dev_clk = 1'b1;
        if (k == 1 && d[0]) check("edge_to_data_oe", first_drop, 3);
        repeat (HALF) @(negedge clk);
        if (k == 11) dev_data = 1'b1;
      end
      if (mode == 2) check("bits_first5", 32'(got_bits[9:5]), 32'(exp_bits[4:0]));
      else begin
        check("frame_bits", 32'(got_bits), 32'(exp_bits));
        check("parity_bit", 32'(got_bits[8]), 32'(p));
      end
    end
    guard = 0;
    while (done_cnt == base && guard < START_TO + XFER_TO + 100) begin
      @(posedge clk);
      guard++;
    end
    #1;
    check("done_seen", done_cnt - base, 1);
    check("done_err", done_err, mode);
    check("oe_at_done", done_oe, 0);
    check("ready_at_done", done_ready, 0);
    if (mode == 0 || mode == 3) check("lines_high_before_done", done_lh, 3);
    if (mode == 2) check("xfer_to_cycles", done_cyc - t_fall, XFER_TO + 3);
    check("ready_after_done", 32'(tx_ready), 1);
    check("busy_after_done", 32'(busy), 0);
    repeat (5) @(posedge clk);
    #1;
    check("no_requeue", 32'(ps2_clk_oe), 0);
    check("single_done", done_cnt - base, 1);
  endtask

  task automatic reset_mid_shift();
    int guard;
    @(negedge clk);
    tx_data  = 8'h00;
    tx_valid = 1'b1;
    @(posedge clk); #1;
    tx_valid = 1'b0;
    guard = 0;
    while (ps2_clk_oe === 1'b1 && guard < INH + 20) begin
      @(posedge clk); #1;
      guard++;
    end
    repeat (8) @(negedge clk);
    for (int k = 1; k <= 4; k++) begin
      dev_clk = 1'b0;
      repeat (HALF) @(negedge clk);
      dev_clk = 1'b1;
      repeat (HALF) @(negedge clk);
    end
    dev_clk = 1'b0;
    repeat (6) @(negedge clk);
    check("pre_reset_data_oe", 32'(ps2_data_oe), 1);
    check("pre_reset_busy", 32'(busy), 1);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_rst_clk_oe", 32'(ps2_clk_oe), 0);
    check("async_rst_data_oe", 32'(ps2_data_oe), 0);
    check("async_rst_ready", 32'(tx_ready), 1);
    check("async_rst_busy", 32'(busy), 0);
    check("async_rst_err", 32'(tx_err), 0);
    dev_clk = 1'b1;
    @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    reset_n  = 1'b0;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    dev_clk  = 1'b1;
    dev_data = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", 32'(tx_ready), 1);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(tx_done), 0);
    check("rst_err", 32'(tx_err), 0);
    check("rst_oe", 32'({ps2_clk_oe, ps2_data_oe}), 0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);

    xfer(8'hF4, 0, 1'b0);
    xfer(8'hED, 0, 1'b0);
    xfer(8'h01, 0, 1'b0);
    xfer(8'($urandom), 1, 1'b0);
    xfer(8'($urandom), 2, 1'b0);
    xfer(8'($urandom), 3, 1'b0);
    for (int i = 0; i < 6; i++) xfer(8'($urandom), 0, i == 2);
    reset_mid_shift();
    xfer(8'hFF, 0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
